// File: rtl/axi_lite_mem_responder.sv
// AXI4-Lite slave backed by a small word-addressed register memory, with byte strobes,
// a configurable read latency, SLVERR on out-of-range accesses and transaction counters.
module axi_lite_mem_responder #(
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 8,
  parameter int unsigned MEM_DEPTH          = 16,
  parameter int unsigned RD_LATENCY         = 2
) (
  input  logic                            ACLK,
  input  logic                            ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic [15:0]                     WR_COUNT,
  output logic [15:0]                     RD_COUNT,
  output logic [7:0]                      ERR_COUNT
);

  localparam int unsigned DW    = C_S_AXI_DATA_WIDTH;
  localparam int unsigned AW    = C_S_AXI_ADDR_WIDTH;
  localparam int unsigned IdxW  = AW - 2;
  localparam int unsigned SlotW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int unsigned StrbW = DW / 8;
  localparam logic [3:0]  LatLoad = (RD_LATENCY == 0) ? 4'd0 : 4'(RD_LATENCY - 1);
  localparam logic [1:0]  RespOkay   = 2'b00;
  localparam logic [1:0]  RespSlvErr = 2'b10;

  typedef enum logic {WIdle, WResp} w_state_e;
  typedef enum logic [1:0] {RIdle, RWait, RResp} r_state_e;

  logic [DW-1:0] mem_q [MEM_DEPTH];
  logic [DW-1:0] mem_d [MEM_DEPTH];

  // Write path state
  w_state_e         w_state_q, w_state_d;
  logic             aw_held_q, aw_held_d;
  logic             w_held_q, w_held_d;
  logic [IdxW-1:0]  awidx_q, awidx_d;
  logic [DW-1:0]    wdata_q, wdata_d;
  logic [StrbW-1:0] wstrb_q, wstrb_d;
  logic             awready_q, awready_d;
  logic             wready_q, wready_d;
  logic             bvalid_q, bvalid_d;
  logic [1:0]       bresp_q, bresp_d;
  logic             wr_in_range;

  // Read path state
  r_state_e         r_state_q, r_state_d;
  logic [IdxW-1:0]  aridx_q, aridx_d;
  logic [3:0]       rcnt_q, rcnt_d;
  logic             arready_q, arready_d;
  logic             rvalid_q, rvalid_d;
  logic [DW-1:0]    rdata_q, rdata_d;
  logic [1:0]       rresp_q, rresp_d;
  logic [IdxW-1:0]  rd_idx;
  logic             rd_in_range;
  logic             rd_sample;

  logic [15:0] wr_count_q, wr_count_d;
  logic [15:0] rd_count_q, rd_count_d;
  logic [7:0]  err_count_q, err_count_d;
  logic [9:0]  err_sum;

  logic aw_hs, w_hs, ar_hs, b_hs, r_hs;

  assign aw_hs = S_AXI_AWVALID & awready_q;
  assign w_hs  = S_AXI_WVALID & wready_q;
  assign ar_hs = S_AXI_ARVALID & arready_q;
  assign b_hs  = bvalid_q & S_AXI_BREADY;
  assign r_hs  = rvalid_q & S_AXI_RREADY;

  logic unused_ok;
  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  // Write FSM: AW and W latch independently; the commit uses a channel accepted on this same edge.
  always_comb begin
    w_state_d   = w_state_q;
    aw_held_d   = aw_held_q;
    w_held_d    = w_held_q;
    awidx_d     = awidx_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    bvalid_d    = bvalid_q;
    bresp_d     = bresp_q;
    mem_d       = mem_q;
    wr_in_range = 1'b0;
    unique case (w_state_q)
      WIdle: begin
        if (aw_hs) begin
          aw_held_d = 1'b1;
          awidx_d   = S_AXI_AWADDR[AW-1:2];
        end
        if (w_hs) begin
          w_held_d = 1'b1;
          wdata_d  = S_AXI_WDATA;
          wstrb_d  = S_AXI_WSTRB;
        end
        wr_in_range = 32'(awidx_d) < MEM_DEPTH;
        if (aw_held_d && w_held_d) begin
          aw_held_d = 1'b0;
          w_held_d  = 1'b0;
          w_state_d = WResp;
          bvalid_d  = 1'b1;
          if (wr_in_range) begin
            bresp_d = RespOkay;
            for (int b = 0; b < int'(StrbW); b++) begin
              if (wstrb_d[b]) mem_d[awidx_d[SlotW-1:0]][8*b +: 8] = wdata_d[8*b +: 8];
            end
          end else begin
            bresp_d = RespSlvErr;
          end
        end
      end
      WResp: begin
        if (S_AXI_BREADY) begin
          bvalid_d  = 1'b0;
          w_state_d = WIdle;
        end
      end
      default: w_state_d = WIdle;
    endcase
    awready_d = (w_state_d == WIdle) && !aw_held_d;
    wready_d  = (w_state_d == WIdle) && !w_held_d;
  end

  // Read FSM: memory is sampled on the edge entering RResp, so a same-edge write is not seen.
  always_comb begin
    r_state_d   = r_state_q;
    aridx_d     = aridx_q;
    rcnt_d      = rcnt_q;
    rvalid_d    = rvalid_q;
    rdata_d     = rdata_q;
    rresp_d     = rresp_q;
    rd_sample   = 1'b0;
    rd_idx      = (r_state_q == RIdle) ? S_AXI_ARADDR[AW-1:2] : aridx_q;
    rd_in_range = 32'(rd_idx) < MEM_DEPTH;
    unique case (r_state_q)
      RIdle: begin
        if (ar_hs) begin
          aridx_d = S_AXI_ARADDR[AW-1:2];
          if (RD_LATENCY == 0) begin
            rd_sample = 1'b1;
          end else begin
            rcnt_d    = LatLoad;
            r_state_d = RWait;
          end
        end
      end
      RWait: begin
        if (rcnt_q == 4'd0) rd_sample = 1'b1;
        else rcnt_d = rcnt_q - 4'd1;
      end
      RResp: begin
        if (S_AXI_RREADY) begin
          rvalid_d  = 1'b0;
          r_state_d = RIdle;
        end
      end
      default: r_state_d = RIdle;
    endcase
    if (rd_sample) begin
      r_state_d = RResp;
      rvalid_d  = 1'b1;
      rdata_d   = rd_in_range ? mem_q[rd_idx[SlotW-1:0]] : '0;
      rresp_d   = rd_in_range ? RespOkay : RespSlvErr;
    end
    arready_d = (r_state_d == RIdle);
  end

  always_comb begin
    wr_count_d  = wr_count_q + 16'(b_hs);
    rd_count_d  = rd_count_q + 16'(r_hs);
    err_sum     = {2'b00, err_count_q} + 10'(b_hs && (bresp_q == RespSlvErr))
                + 10'(r_hs && (rresp_q == RespSlvErr));
    err_count_d = (err_sum > 10'd255) ? 8'hFF : err_sum[7:0];
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      mem_q       <= '{default: '0};
      w_state_q   <= WIdle;
      aw_held_q   <= 1'b0;
      w_held_q    <= 1'b0;
      awidx_q     <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      awready_q   <= 1'b0;
      wready_q    <= 1'b0;
      bvalid_q    <= 1'b0;
      bresp_q     <= RespOkay;
      r_state_q   <= RIdle;
      aridx_q     <= '0;
      rcnt_q      <= 4'd0;
      arready_q   <= 1'b0;
      rvalid_q    <= 1'b0;
      rdata_q     <= '0;
      rresp_q     <= RespOkay;
      wr_count_q  <= 16'd0;
      rd_count_q  <= 16'd0;
      err_count_q <= 8'd0;
    end else begin
      mem_q       <= mem_d;
      w_state_q   <= w_state_d;
      aw_held_q   <= aw_held_d;
      w_held_q    <= w_held_d;
      awidx_q     <= awidx_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      awready_q   <= awready_d;
      wready_q    <= wready_d;
      bvalid_q    <= bvalid_d;
      bresp_q     <= bresp_d;
      r_state_q   <= r_state_d;
      aridx_q     <= aridx_d;
      rcnt_q      <= rcnt_d;
      arready_q   <= arready_d;
      rvalid_q    <= rvalid_d;
      rdata_q     <= rdata_d;
      rresp_q     <= rresp_d;
      wr_count_q  <= wr_count_d;
      rd_count_q  <= rd_count_d;
      err_count_q <= err_count_d;
    end
  end

  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = wready_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = rresp_q;
  assign WR_COUNT      = wr_count_q;
  assign RD_COUNT      = rd_count_q;
  assign ERR_COUNT     = err_count_q;

endmodule

// File: tb/tb_axi_lite_mem_responder.sv
// Directed bench for axi_lite_mem_responder: hand-computed expectations checked with immediate
// assertions, covering reset, strobes, SLVERR, stalls, latency, collisions and counter saturation.
module tb_axi_lite_mem_responder;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic [7:0]  S_AXI_AWADDR;
  logic [2:0]  S_AXI_AWPROT;
  logic        S_AXI_AWVALID;
  logic        S_AXI_AWREADY;
  logic [31:0] S_AXI_WDATA;
  logic [3:0]  S_AXI_WSTRB;
  logic        S_AXI_WVALID;
  logic        S_AXI_WREADY;
  logic [1:0]  S_AXI_BRESP;
  logic        S_AXI_BVALID;
  logic        S_AXI_BREADY;
  logic [7:0]  S_AXI_ARADDR;
  logic [2:0]  S_AXI_ARPROT;
  logic        S_AXI_ARVALID;
  logic        S_AXI_ARREADY;
  logic [31:0] S_AXI_RDATA;
  logic [1:0]  S_AXI_RRESP;
  logic        S_AXI_RVALID;
  logic        S_AXI_RREADY;
  logic [15:0] WR_COUNT;
  logic [15:0] RD_COUNT;
  logic [7:0]  ERR_COUNT;

  int checks = 0;
  int errors = 0;

  axi_lite_mem_responder dut (
    .ACLK          (ACLK),
    .ARESET        (ARESET),
    .S_AXI_AWADDR  (S_AXI_AWADDR),
    .S_AXI_AWPROT  (S_AXI_AWPROT),
    .S_AXI_AWVALID (S_AXI_AWVALID),
    .S_AXI_AWREADY (S_AXI_AWREADY),
    .S_AXI_WDATA   (S_AXI_WDATA),
    .S_AXI_WSTRB   (S_AXI_WSTRB),
    .S_AXI_WVALID  (S_AXI_WVALID),
    .S_AXI_WREADY  (S_AXI_WREADY),
    .S_AXI_BRESP   (S_AXI_BRESP),
    .S_AXI_BVALID  (S_AXI_BVALID),
    .S_AXI_BREADY  (S_AXI_BREADY),
    .S_AXI_ARADDR  (S_AXI_ARADDR),
    .S_AXI_ARPROT  (S_AXI_ARPROT),
    .S_AXI_ARVALID (S_AXI_ARVALID),
    .S_AXI_ARREADY (S_AXI_ARREADY),
    .S_AXI_RDATA   (S_AXI_RDATA),
    .S_AXI_RRESP   (S_AXI_RRESP),
    .S_AXI_RVALID  (S_AXI_RVALID),
    .S_AXI_RREADY  (S_AXI_RREADY),
    .WR_COUNT      (WR_COUNT),
    .RD_COUNT      (RD_COUNT),
    .ERR_COUNT     (ERR_COUNT)
  );

  always #5 ACLK = ~ACLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic axi_write(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           output logic [1:0] resp);
    bit aw_done = 1'b0;
    bit w_done  = 1'b0;
    bit aw_fire, w_fire;
    int n = 0;
    S_AXI_AWADDR  = addr;
    S_AXI_WDATA   = data;
    S_AXI_WSTRB   = strb;
    S_AXI_AWVALID = 1'b1;
    S_AXI_WVALID  = 1'b1;
    while (!(aw_done && w_done) && n < 20) begin
      aw_fire = S_AXI_AWVALID && S_AXI_AWREADY;
      w_fire  = S_AXI_WVALID && S_AXI_WREADY;
      tick();
      if (aw_fire) begin S_AXI_AWVALID = 1'b0; aw_done = 1'b1; end
      if (w_fire) begin S_AXI_WVALID = 1'b0; w_done = 1'b1; end
      n++;
    end
    S_AXI_AWVALID = 1'b0;
    S_AXI_WVALID  = 1'b0;
    check("wr_accept_timeout", 32'(aw_done && w_done), 32'd1);
    S_AXI_BREADY = 1'b1;
    n = 0;
    while (!S_AXI_BVALID && n < 20) begin tick(); n++; end
    check("bvalid_timeout", 32'(S_AXI_BVALID), 32'd1);
    resp = S_AXI_BRESP;
    tick();
    S_AXI_BREADY = 1'b0;
  endtask

  task automatic axi_read(input logic [7:0] addr, input int hold, output logic [31:0] data,
                          output logic [1:0] resp, output int lat);
    bit fire = 1'b0;
    int n = 0;
    S_AXI_ARADDR  = addr;
    S_AXI_ARVALID = 1'b1;
    while (!fire && n < 20) begin
      fire = S_AXI_ARVALID && S_AXI_ARREADY;
      tick();
      n++;
    end
    S_AXI_ARVALID = 1'b0;
    check("ar_accept_timeout", 32'(fire), 32'd1);
    lat = 0;
    while (!S_AXI_RVALID && lat < 40) begin tick(); lat++; end
    check("rvalid_timeout", 32'(S_AXI_RVALID), 32'd1);
    data = S_AXI_RDATA;
    resp = S_AXI_RRESP;
    for (int i = 0; i < hold; i++) begin
      tick();
      check("rvalid_hold", 32'(S_AXI_RVALID), 32'd1);
    end
    S_AXI_RREADY = 1'b1;
    tick();
    S_AXI_RREADY = 1'b0;
  endtask

  initial begin
    logic [1:0]  resp;
    logic [31:0] data;
    int          lat;
    bit          seen;

    ARESET = 1'b1;
    S_AXI_AWADDR = '0; S_AXI_AWPROT = '0; S_AXI_AWVALID = 1'b0;
    S_AXI_WDATA = '0; S_AXI_WSTRB = '0; S_AXI_WVALID = 1'b0; S_AXI_BREADY = 1'b0;
    S_AXI_ARADDR = '0; S_AXI_ARPROT = '0; S_AXI_ARVALID = 1'b0; S_AXI_RREADY = 1'b0;
    repeat (3) tick();

    // Reset state
    check("rst_awready", 32'(S_AXI_AWREADY), 32'd0);
    check("rst_wready", 32'(S_AXI_WREADY), 32'd0);
    check("rst_arready", 32'(S_AXI_ARREADY), 32'd0);
    check("rst_bvalid", 32'(S_AXI_BVALID), 32'd0);
    check("rst_rvalid", 32'(S_AXI_RVALID), 32'd0);
    check("rst_rdata", S_AXI_RDATA, 32'd0);
    check("rst_counts", {WR_COUNT, RD_COUNT[7:0], ERR_COUNT}, 32'd0);
    ARESET = 1'b0;
    check("ready_before_edge", 32'(S_AXI_AWREADY), 32'd0);
    tick();
    check("awready_first_edge", 32'(S_AXI_AWREADY), 32'd1);
    check("wready_first_edge", 32'(S_AXI_WREADY), 32'd1);
    check("arready_first_edge", 32'(S_AXI_ARREADY), 32'd1);

    // Basic write then read-back of four words
    for (int i = 0; i < 4; i++) begin
      axi_write(8'(4 * i), 32'(i + 1), 4'hF, resp);
      check("basic_bresp", 32'(resp), 32'd0);
    end
    for (int i = 0; i < 4; i++) begin
      axi_read(8'(4 * i), 0, data, resp, lat);
      check("basic_rdata", data, 32'(i + 1));
      check("basic_rresp", 32'(resp), 32'd0);
    end
    check("basic_wr_count", 32'(WR_COUNT), 32'd4);
    check("basic_rd_count", 32'(RD_COUNT), 32'd4);

    // Byte strobes
    axi_write(8'h10, 32'hFFFF_FFFF, 4'hF, resp);
    axi_write(8'h10, 32'h1234_5678, 4'b0101, resp);
    axi_read(8'h10, 0, data, resp, lat);
    check("strb_rdata", data, 32'hFF34_FF78);

    // Out-of-range write and read; index 16 must not alias word 0
    axi_write(8'h40, 32'hDEAD_BEEF, 4'hF, resp);
    check("oor_bresp", 32'(resp), 32'd2);
    axi_read(8'h40, 0, data, resp, lat);
    check("oor_rresp", 32'(resp), 32'd2);
    check("oor_rdata", data, 32'd0);
    check("oor_err_count", 32'(ERR_COUNT), 32'd2);
    axi_read(8'h00, 0, data, resp, lat);
    check("oor_no_alias", data, 32'd1);
    axi_read(8'h0B, 0, data, resp, lat);
    check("low_bits_ignored", data, 32'd3);

    // AW three cycles ahead of W, BREADY held low five cycles
    S_AXI_AWADDR = 8'h14; S_AXI_AWVALID = 1'b1;
    tick();
    S_AXI_AWVALID = 1'b0;
    check("aw_latched_awready", 32'(S_AXI_AWREADY), 32'd0);
    check("aw_latched_wready", 32'(S_AXI_WREADY), 32'd1);
    tick();
    tick();
    check("aw_only_no_b", 32'(S_AXI_BVALID), 32'd0);
    S_AXI_WDATA = 32'hCAFE_F00D; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
    tick();
    S_AXI_WVALID = 1'b0;
    check("stall_bvalid_rise", 32'(S_AXI_BVALID), 32'd1);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_bvalid_hold", 32'(S_AXI_BVALID), 32'd1);
      check("stall_ready_low", 32'(S_AXI_AWREADY | S_AXI_WREADY), 32'd0);
      check("stall_wr_count", 32'(WR_COUNT), 32'd7);
    end
    S_AXI_BREADY = 1'b1;
    tick();
    S_AXI_BREADY = 1'b0;
    check("stall_wr_count_after", 32'(WR_COUNT), 32'd8);
    check("stall_bvalid_drop", 32'(S_AXI_BVALID), 32'd0);

    // Read latency, with RVALID held through an RREADY stall
    axi_read(8'h14, 3, data, resp, lat);
    check("stall_rdata", data, 32'hCAFE_F00D);
    check("rd_latency", 32'(lat), 32'd2);

    // Write committing on the same edge the read samples the word: old data returned
    S_AXI_ARADDR = 8'h00; S_AXI_ARVALID = 1'b1;
    tick();
    S_AXI_ARVALID = 1'b0;
    tick();
    S_AXI_AWADDR = 8'h00; S_AXI_WDATA = 32'h55; S_AXI_WSTRB = 4'hF;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1; S_AXI_BREADY = 1'b1;
    tick();
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    check("coll_rvalid", 32'(S_AXI_RVALID), 32'd1);
    check("coll_bvalid", 32'(S_AXI_BVALID), 32'd1);
    check("coll_old_data", S_AXI_RDATA, 32'd1);
    S_AXI_RREADY = 1'b1;
    tick();
    S_AXI_RREADY = 1'b0; S_AXI_BREADY = 1'b0;
    axi_read(8'h00, 0, data, resp, lat);
    check("coll_new_data", data, 32'h55);
    check("coll_wr_count", 32'(WR_COUNT), 32'd9);
    check("coll_rd_count", 32'(RD_COUNT), 32'd11);

    // Reset during RWait
    axi_write(8'h00, 32'hA5, 4'hF, resp);
    S_AXI_ARADDR = 8'h00; S_AXI_ARVALID = 1'b1;
    tick();
    S_AXI_ARVALID = 1'b0;
    ARESET = 1'b1;
    #2;
    check("mid_rst_rvalid", 32'(S_AXI_RVALID), 32'd0);
    check("mid_rst_arready", 32'(S_AXI_ARREADY), 32'd0);
    check("mid_rst_counts", {WR_COUNT, RD_COUNT[7:0], ERR_COUNT}, 32'd0);
    tick();
    ARESET = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (S_AXI_RVALID) seen = 1'b1;
    end
    check("mid_rst_no_rvalid", 32'(seen), 32'd0);
    axi_read(8'h00, 0, data, resp, lat);
    check("mid_rst_mem_cleared", data, 32'd0);
    check("mid_rst_rresp", 32'(resp), 32'd0);
    check("mid_rst_rd_count", 32'(RD_COUNT), 32'd1);
    check("mid_rst_wr_count", 32'(WR_COUNT), 32'd0);

    // ERR_COUNT saturation
    for (int i = 0; i < 254; i++) axi_read(8'h40, 0, data, resp, lat);
    check("err_count_254", 32'(ERR_COUNT), 32'd254);
    axi_read(8'h40, 0, data, resp, lat);
    axi_read(8'h40, 0, data, resp, lat);
    check("err_count_sat", 32'(ERR_COUNT), 32'd255);
    check("rd_count_257", 32'(RD_COUNT), 32'd257);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
